// File: rtl/i2c_ccd_slave_pkg.sv
// Shared types and constants for the CCD register-port I2C responder.
// The read path (TX states) exists only when I2C_SLAVE_READ_EN is defined.
package i2c_ccd_pkg;

  // 7-bit device address: write byte 0xBA, read byte 0xBB.
  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h5D;

  // SDA levels seen on the bus during an acknowledge bit.
  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEV,
    ST_ACK_D,
    ST_REG,
    ST_DAT_HI,
    ST_DAT_LO
`ifdef I2C_SLAVE_READ_EN
    , ST_TX_HI
    , ST_TX_LO
`endif
  } state_e;

endpackage

// File: rtl/i2c_ccd_slave_if.sv
// Bus-side bundle of the CCD register-port responder.
// Signalling: iSCL/iSDA are raw open-drain pad levels, and oSDA_OE=1 pulls SDA
// low. oREG_WE is a one-cycle valid strobe qualifying oREG_ADDR/oREG_WDATA; it
// has no ready, so the consumer must take every word in the cycle it appears.
// dbgState and the dbgRdAddr/dbgRdData peek port are observation-only.
interface i2c_ccd_slave_if #(parameter int AW = 5);
  import i2c_ccd_pkg::*;

  logic          iSCL;
  logic          iSDA;
  logic          oSDA_OE;
  logic          oREG_WE;
  logic [7:0]    oREG_ADDR;
  logic [15:0]   oREG_WDATA;
  logic          oBUSY;
  state_e        dbgState;
  logic [AW-1:0] dbgRdAddr;
  logic [15:0]   dbgRdData;

  modport slave (
    input  iSCL, iSDA, dbgRdAddr,
    output oSDA_OE, oREG_WE, oREG_ADDR, oREG_WDATA, oBUSY, dbgState, dbgRdData
  );

  modport master (
    output iSCL, iSDA, dbgRdAddr,
    input  oSDA_OE, oREG_WE, oREG_ADDR, oREG_WDATA, oBUSY, dbgState, dbgRdData
  );

endinterface

// File: rtl/i2c_ccd_slave_sync.sv
// i2c_bus_sync: two-flop synchronizers plus a history flop on SCL and SDA,
// producing single-cycle START/STOP and SCL rise/fall pulses. Reusable by a
// master-side bus monitor.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sdaLvl,
  output logic sclRise,
  output logic sclFall,
  output logic startDet,
  output logic stopDet
);

  // Bit 0 = metastability flop, bit 1 = synchronized level, bit 2 = history.
  logic [2:0] sclPipe;
  logic [2:0] sdaPipe;

  // Shift pad levels in; reset to the idle-high bus so no event fires on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclPipe <= 3'b111;
      sdaPipe <= 3'b111;
    end else begin
      sclPipe <= {sclPipe[1:0], scl};
      sdaPipe <= {sdaPipe[1:0], sda};
    end
  end

  assign sdaLvl   = sdaPipe[1];
  assign sclRise  =  sclPipe[1] & ~sclPipe[2];
  assign sclFall  = ~sclPipe[1] &  sclPipe[2];
  // SDA edges only count as conditions while SCL is steadily high.
  assign startDet =  sclPipe[1] & sclPipe[2] &  sdaPipe[2] & ~sdaPipe[1];
  assign stopDet  =  sclPipe[1] & sclPipe[2] & ~sdaPipe[2] &  sdaPipe[1];

endmodule

// File: rtl/i2c_ccd_slave.sv
// i2c_ccd_slave: I2C responder modelling the CCD register port
// (8-bit register address, then 16-bit words MSB first, auto-incrementing).
// Optional read path built when I2C_SLAVE_READ_EN is defined.
module i2c_ccd_slave
  import i2c_ccd_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR,
  parameter int         AW       = 5
) (
  input logic            iCLK,
  input logic            iRST,
  i2c_ccd_slave_if.slave bus
);

  logic sdaLvl, sclRise, sclFall, startDet, stopDet;

  i2c_bus_sync uSync (
    .clk     (iCLK),
    .rst     (iRST),
    .scl     (bus.iSCL),
    .sda     (bus.iSDA),
    .sdaLvl  (sdaLvl),
    .sclRise (sclRise),
    .sclFall (sclFall),
    .startDet(startDet),
    .stopDet (stopDet)
  );

  state_e      state;
  logic [3:0]  bitCnt;    // SCL rises seen in the current byte (8 = in ACK slot)
  logic        ackPhase;  // ACK slot of a register/data/tx byte is in progress
  logic [7:0]  rxShift;
  logic [7:0]  hiByte;
  logic [7:0]  ptr;
  logic        sdaOe;
  logic        regWe;
  logic [7:0]  regAddr;
  logic [15:0] regWdata;
  logic        busy;
  logic [15:0] regs [2**AW];
`ifdef I2C_SLAVE_READ_EN
  logic [15:0] txWord;    // MSB is the next bit to put on SDA
  logic        mAck;      // master acknowledged the byte just sent
`endif

  logic devMatch;
  assign devMatch = (rxShift[7:1] == DEV_ADDR);

  // Protocol FSM: bit counting, ACK generation, pointer, commits and read-out.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state    <= ST_IDLE;
      bitCnt   <= '0;
      ackPhase <= 1'b0;
      rxShift  <= '0;
      hiByte   <= '0;
      ptr      <= '0;
      sdaOe    <= 1'b0;
      regWe    <= 1'b0;
      regAddr  <= '0;
      regWdata <= '0;
      busy     <= 1'b0;
      for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
`ifdef I2C_SLAVE_READ_EN
      txWord   <= '0;
      mAck     <= 1'b0;
`endif
    end else begin
      regWe <= 1'b0;
      if (startDet) begin
        // Repeated START drops any partial byte but keeps the pointer.
        state    <= ST_DEV;
        bitCnt   <= '0;
        ackPhase <= 1'b0;
        sdaOe    <= 1'b0;
        busy     <= 1'b1;
      end else if (stopDet) begin
        state    <= ST_IDLE;
        bitCnt   <= '0;
        ackPhase <= 1'b0;
        sdaOe    <= 1'b0;
        busy     <= 1'b0;
      end else if (sclRise && state != ST_IDLE) begin
        if (bitCnt < 4'd8) begin
          rxShift <= {rxShift[6:0], sdaLvl};
          bitCnt  <= bitCnt + 4'd1;
          // The 16th data bit completes a word: commit before the ACK slot.
          if (state == ST_DAT_LO && bitCnt == 4'd7) begin
            regs[ptr[AW-1:0]] <= {hiByte, rxShift[6:0], sdaLvl};
            regWe    <= 1'b1;
            regAddr  <= ptr;
            regWdata <= {hiByte, rxShift[6:0], sdaLvl};
            ptr      <= ptr + 8'd1;
          end
        end else begin
`ifdef I2C_SLAVE_READ_EN
          mAck <= (sdaLvl == SDA_ACK);
`endif
        end
      end else if (sclFall && state != ST_IDLE) begin
        case (state)
          ST_DEV: begin
            if (bitCnt == 4'd8) begin
              if (devMatch && !rxShift[0]) begin
                sdaOe <= ~SDA_ACK;
                state <= ST_ACK_D;
              end
`ifdef I2C_SLAVE_READ_EN
              else if (devMatch) begin
                sdaOe <= ~SDA_ACK;
                state <= ST_ACK_D;
              end
`endif
              else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_ACK_D: begin
            bitCnt <= '0;
            sdaOe  <= 1'b0;
            state  <= ST_REG;
`ifdef I2C_SLAVE_READ_EN
            if (rxShift[0]) begin
              // First read bit goes out on the fall that ends the address ACK.
              state  <= ST_TX_HI;
              txWord <= regs[ptr[AW-1:0]];
              sdaOe  <= ~regs[ptr[AW-1:0]][15];
            end
`endif
          end
          ST_REG, ST_DAT_HI, ST_DAT_LO: begin
            if (ackPhase) begin
              ackPhase <= 1'b0;
              bitCnt   <= '0;
              sdaOe    <= 1'b0;
              state    <= (state == ST_DAT_HI) ? ST_DAT_LO : ST_DAT_HI;
            end else if (bitCnt == 4'd8) begin
              ackPhase <= 1'b1;
              sdaOe    <= ~SDA_ACK;
              if (state == ST_REG)    ptr    <= rxShift;
              if (state == ST_DAT_HI) hiByte <= rxShift;
            end
          end
`ifdef I2C_SLAVE_READ_EN
          ST_TX_HI, ST_TX_LO: begin
            if (ackPhase) begin
              ackPhase <= 1'b0;
              bitCnt   <= '0;
              if (!mAck) begin
                state <= ST_IDLE;
                sdaOe <= 1'b0;
              end else if (state == ST_TX_HI) begin
                state <= ST_TX_LO;
                sdaOe <= ~txWord[15];
              end else begin
                state  <= ST_TX_HI;
                txWord <= regs[ptr[AW-1:0]];
                sdaOe  <= ~regs[ptr[AW-1:0]][15];
              end
            end else if (bitCnt == 4'd8) begin
              // Release SDA so the master can drive its ACK/NACK.
              ackPhase <= 1'b1;
              sdaOe    <= 1'b0;
              txWord   <= {txWord[14:0], 1'b0};
              if (state == ST_TX_LO) ptr <= ptr + 8'd1;
            end else if (bitCnt != 4'd0) begin
              txWord <= {txWord[14:0], 1'b0};
              sdaOe  <= ~txWord[14];
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.oSDA_OE    = sdaOe;
  assign bus.oREG_WE    = regWe;
  assign bus.oREG_ADDR  = regAddr;
  assign bus.oREG_WDATA = regWdata;
  assign bus.oBUSY      = busy;
  assign bus.dbgState   = state;
  assign bus.dbgRdData  = regs[bus.dbgRdAddr];

endmodule

// File: tb/tb_i2c_ccd_slave.sv
// Bench for i2c_ccd_slave: bit-banged I2C master, transaction-level register
// model, table-driven write vectors, random writes/reads, hand-written corners.
module tb_i2c_ccd_slave;
  import i2c_ccd_pkg::*;

  localparam int Q = 4;  // iCLK cycles per quarter SCL period

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_ccd_slave_if #(.AW(5)) bus();

  logic mScl, mSda, sdaLine;
  assign sdaLine  = mSda & ~bus.oSDA_OE;
  assign bus.iSCL = mScl;
  assign bus.iSDA = sdaLine;

  i2c_ccd_slave #(.DEV_ADDR(7'h5D), .AW(5)) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  logic [15:0] mRegs [32];
  logic [7:0]  mPtr;
  logic [7:0]  dataBuf [8];
  int weLong = 0;
  logic wePrev = 1'b0;

  always @(negedge clk) begin
    if (bus.oREG_WE) begin
      got_q.push_back({bus.oREG_ADDR, bus.oREG_WDATA});
      if (wePrev) weLong++;
    end
    wePrev = bus.oREG_WE;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mRegs[i] = '0;
    mPtr = '0;
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic i2cStart();
    mSda = 1'b1; waitClk(Q);
    mScl = 1'b1; waitClk(Q);
    mSda = 1'b0; waitClk(Q);
    mScl = 1'b0; waitClk(Q);
  endtask

  task automatic i2cStop();
    mSda = 1'b0; waitClk(Q);
    mScl = 1'b1; waitClk(Q);
    mSda = 1'b1; waitClk(Q);
  endtask

  task automatic writeByte(input logic [7:0] b, input logic rstMid, output logic acked);
    for (int i = 7; i >= 0; i--) begin
      mSda = b[i]; waitClk(Q);
      mScl = 1'b1; waitClk(2 * Q);
      mScl = 1'b0;
    end
    waitClk(1); mSda = 1'b1; waitClk(Q);
    mScl = 1'b1; waitClk(Q);
    acked = (sdaLine == 1'b0);
    if (rstMid) begin
      check("rst ack driven", 32'(bus.oSDA_OE), 32'd1);
      rst = 1'b1;
      #1;
      check("rst async oe drop", 32'(bus.oSDA_OE), 32'd0);
      waitClk(3);
      rst = 1'b0;
      modelReset();
    end
    waitClk(Q); mScl = 1'b0;
  endtask

  task automatic readByte(input logic ackIt, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      waitClk(Q); mScl = 1'b1;
      waitClk(Q); b[i] = sdaLine;
      waitClk(Q); mScl = 1'b0;
    end
    waitClk(1); mSda = ~ackIt; waitClk(Q);
    mScl = 1'b1; waitClk(2 * Q);
    mScl = 1'b0; waitClk(Q);
    mSda = 1'b1;
  endtask

  task automatic peek(input logic [4:0] a, output logic [15:0] d);
    bus.dbgRdAddr = a;
    waitClk(1);
    d = bus.dbgRdData;
  endtask

  task automatic compareCommits(input string tag);
    check({tag, " ncommit"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, " commit"}, {8'h0, got_q.pop_front()}, {8'h0, exp_q.pop_front()});
    exp_q.delete();
    got_q.delete();
  endtask

  // Write transaction: dev byte, register byte, nData bytes from dataBuf, STOP.
  task automatic runWrite(input logic [7:0] dev, input logic [7:0] regA, input int nData,
                          input logic expAck, input int expCommits, input string tag);
    logic ack;
    logic [15:0] word;
    i2cStart();
    check({tag, " busy"}, 32'(bus.oBUSY), 32'd1);
    writeByte(dev, 1'b0, ack);
    check({tag, " devack"}, 32'(ack), 32'(expAck));
    if (expAck) begin
      writeByte(regA, 1'b0, ack);
      check({tag, " regack"}, 32'(ack), 32'd1);
      mPtr = regA;
      for (int i = 0; i < nData; i++) begin
        writeByte(dataBuf[i], 1'b0, ack);
        check({tag, " dataack"}, 32'(ack), 32'd1);
        if (i % 2 == 1) begin
          word = {dataBuf[i-1], dataBuf[i]};
          exp_q.push_back({mPtr, word});
          mRegs[mPtr[4:0]] = word;
          mPtr = mPtr + 8'd1;
        end
      end
    end else begin
      waitClk(2);
      check({tag, " nack idle"}, 32'(bus.dbgState), 32'(ST_IDLE));
      check({tag, " nack released"}, 32'(bus.oSDA_OE), 32'd0);
    end
    i2cStop();
    waitClk(6);
    check({tag, " busy after stop"}, 32'(bus.oBUSY), 32'd0);
    check({tag, " idle after stop"}, 32'(bus.dbgState), 32'(ST_IDLE));
    if (expCommits >= 0)
      check({tag, " table ncommit"}, 32'(got_q.size()), 32'(expCommits));
    compareCommits(tag);
  endtask

`ifdef I2C_SLAVE_READ_EN
  // Set pointer, repeated START, read nWords words; master NACKs the last byte.
  task automatic runRead(input logic [7:0] regA, input int nWords, input string tag);
    logic ack;
    logic [7:0] b;
    logic [15:0] word;
    i2cStart();
    writeByte(8'hBA, 1'b0, ack);
    check({tag, " devack"}, 32'(ack), 32'd1);
    writeByte(regA, 1'b0, ack);
    check({tag, " regack"}, 32'(ack), 32'd1);
    mPtr = regA;
    i2cStart();
    writeByte(8'hBB, 1'b0, ack);
    check({tag, " rdack"}, 32'(ack), 32'd1);
    for (int w = 0; w < nWords; w++) begin
      word = mRegs[mPtr[4:0]];
      readByte(1'b1, b);
      check({tag, " rd hi"}, 32'(b), 32'(word[15:8]));
      readByte(w != nWords - 1, b);
      check({tag, " rd lo"}, 32'(b), 32'(word[7:0]));
      mPtr = mPtr + 8'd1;
    end
    check({tag, " released after nack"}, 32'(bus.oSDA_OE), 32'd0);
    check({tag, " idle after nack"}, 32'(bus.dbgState), 32'(ST_IDLE));
    i2cStop();
    waitClk(6);
    check({tag, " no commit on read"}, 32'(got_q.size()), 32'd0);
    got_q.delete();
  endtask
`endif

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] dev;
    logic [7:0] regA;
    int         nData;
    logic [7:0] d [4];
    logic       expAck;
    int         expCommits;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic ack;
    logic [15:0] rd;
    logic [7:0] dev, regA;
    int n;

    vecs[0] = '{dev: 8'hBA, regA: 8'h20, nData: 2, d: '{8'h12, 8'h34, 8'h00, 8'h00}, expAck: 1'b1, expCommits: 1};
    vecs[1] = '{dev: 8'hB8, regA: 8'h00, nData: 0, d: '{8'h00, 8'h00, 8'h00, 8'h00}, expAck: 1'b0, expCommits: 0};
    vecs[2] = '{dev: 8'hBA, regA: 8'hFF, nData: 4, d: '{8'hAA, 8'hAA, 8'h55, 8'h55}, expAck: 1'b1, expCommits: 2};
    vecs[3] = '{dev: 8'hBA, regA: 8'h05, nData: 1, d: '{8'hBE, 8'h00, 8'h00, 8'h00}, expAck: 1'b1, expCommits: 0};
`ifdef I2C_SLAVE_READ_EN
    vecs[4] = '{dev: 8'hBA, regA: 8'h07, nData: 2, d: '{8'hC0, 8'hDE, 8'h00, 8'h00}, expAck: 1'b1, expCommits: 1};
`else
    vecs[4] = '{dev: 8'hBB, regA: 8'h10, nData: 0, d: '{8'h00, 8'h00, 8'h00, 8'h00}, expAck: 1'b0, expCommits: 0};
`endif
    vecs[5] = '{dev: 8'hBA, regA: 8'h07, nData: 3, d: '{8'hDE, 8'hAD, 8'hBE, 8'h00}, expAck: 1'b1, expCommits: 1};

    // Reset state
    rst = 1'b1; mScl = 1'b1; mSda = 1'b1; bus.dbgRdAddr = '0;
    modelReset();
    waitClk(3);
    check("reset oe", 32'(bus.oSDA_OE), 32'd0);
    check("reset we", 32'(bus.oREG_WE), 32'd0);
    check("reset addr", 32'(bus.oREG_ADDR), 32'd0);
    check("reset wdata", 32'(bus.oREG_WDATA), 32'd0);
    check("reset busy", 32'(bus.oBUSY), 32'd0);
    check("reset state", 32'(bus.dbgState), 32'(ST_IDLE));
    check("reset reg0", 32'(bus.dbgRdData), 32'd0);
    rst = 1'b0;
    waitClk(4);

    // Table-driven write vectors
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 4; k++) dataBuf[k] = vecs[v].d[k];
      runWrite(vecs[v].dev, vecs[v].regA, vecs[v].nData, vecs[v].expAck,
               vecs[v].expCommits, $sformatf("vec%0d", v));
    end
    peek(5'd31, rd); check("wrap reg 0xFF", 32'(rd), 32'h0000AAAA);
    peek(5'd0,  rd); check("wrap reg 0x00", 32'(rd), 32'h00005555);
    peek(5'd5,  rd); check("partial word reg5", 32'(rd), 32'h00000000);

`ifdef I2C_SLAVE_READ_EN
    // Write 0x20=0x1234, then read it back with NACK after the second byte.
    dataBuf[0] = 8'h12; dataBuf[1] = 8'h34;
    runWrite(8'hBA, 8'h20, 2, 1'b1, 1, "rdprep");
    runRead(8'h20, 1, "read1234");
`endif

    // Random write transactions against the model
    for (int t = 0; t < 16; t++) begin
      dev = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'hBA;
      if (dev[7:1] == 7'h5D) dev = 8'hBA;
      regA = ($urandom_range(0, 3) == 0) ? 8'hFC + 8'($urandom_range(0, 3))
                                         : 8'($urandom_range(0, 255));
      n = $urandom_range(0, 6);
      for (int k = 0; k < 8; k++) dataBuf[k] = 8'($urandom_range(0, 255));
      runWrite(dev, regA, n, dev == 8'hBA, -1, $sformatf("rnd%0d", t));
    end

`ifdef I2C_SLAVE_READ_EN
    for (int t = 0; t < 3; t++)
      runRead(8'($urandom_range(0, 255)), $urandom_range(1, 3), $sformatf("rndrd%0d", t));
`endif

    // Full register sweep against the model
    for (int i = 0; i < 32; i++) begin
      peek(5'(i), rd);
      check($sformatf("sweep reg%0d", i), 32'(rd), 32'(mRegs[i]));
    end

    // Reset pulsed while the device-address ACK is driven
    i2cStart();
    writeByte(8'hBA, 1'b1, ack);
    i2cStop();
    waitClk(6);
    check("post-rst state", 32'(bus.dbgState), 32'(ST_IDLE));
    peek(5'd7, rd); check("post-rst reg7 cleared", 32'(rd), 32'd0);
    dataBuf[0] = 8'h9A; dataBuf[1] = 8'hBC;
    runWrite(8'hBA, 8'h03, 2, 1'b1, 1, "post-rst");
    peek(5'd3, rd); check("post-rst reg3", 32'(rd), 32'h00009ABC);

    check("we one-cycle", 32'(weLong), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
